data_mem_pipe: RTL

//  Parametrised single-port data memory for the MIPS CPU datapath; successor to the combinational-read

---
 rtl/data_mem_pipe.sv | 116 +++++++++++
 1 files changed

// File: rtl/data_mem_pipe.sv
// Single-port data memory for the pipelined MIPS core: byte-lane writes, fixed read latency,
// valid/ready request handshake, post-reset clear sweep and out-of-range error reporting.
module data_mem_pipe #(
  parameter int DATA_W       = 32,
  parameter int RAM_SIZE     = 256,
  parameter int READ_LATENCY = 1,
  parameter int INIT_CLEAR   = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wr,
  input  logic [31:0]         req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                wr_err,
  output logic                init_done
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = (BE_W > 1) ? $clog2(BE_W) : 0;
  localparam int IDX_W = (RAM_SIZE > 1) ? $clog2(RAM_SIZE) : 1;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t             state;
  logic [IDX_W-1:0]   sweep_cnt;

  logic [31:0]        word_idx;
  logic               in_range;
  logic [IDX_W-1:0]   idx;
  logic               accept;
  logic               wr_acc;
  logic               rd_acc;

  // Range check uses the full shifted address so words past the end never alias low words.
  assign word_idx = req_addr >> OFF_W;
  assign in_range = word_idx < 32'(RAM_SIZE);
  assign idx      = word_idx[IDX_W-1:0];
  assign accept   = req_valid & req_ready & ~reset;
  assign wr_acc   = accept & req_wr;
  assign rd_acc   = accept & ~req_wr;

  // NOTE: all sequential state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_INIT;
      sweep_cnt <= '0;
      req_ready <= 1'b0;
      init_done <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          if (INIT_CLEAR == 0 || sweep_cnt == IDX_W'(RAM_SIZE - 1)) begin
            state     <= S_RUN;
            req_ready <= 1'b1;
            init_done <= 1'b1;
          end else begin
            sweep_cnt <= sweep_cnt + IDX_W'(1);
          end
        end
        S_RUN: begin
          req_ready <= 1'b1;
          init_done <= 1'b1;
        end
        default: state <= S_INIT;
      endcase
    end
  end

  logic [DATA_W-1:0] mem [RAM_SIZE];

  // NOTE: the array has no reset so it can map onto RAM; zeroing is done by the sweep instead.
  always_ff @(posedge clk) begin
    if (!reset && state == S_INIT && INIT_CLEAR != 0) begin
      mem[sweep_cnt] <= '0;
    end else if (wr_acc && in_range) begin
      for (int i = 0; i < BE_W; i++) begin
        if (req_be[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  // Read pipeline: stage 0 captures the array at accept, later stages only add delay.
  logic [READ_LATENCY-1:0] pipe_valid;
  logic [READ_LATENCY-1:0] pipe_err;
  logic [DATA_W-1:0]       pipe_data [READ_LATENCY];

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_valid <= '0;
      pipe_err   <= '0;
      wr_err     <= 1'b0;
      for (int i = 0; i < READ_LATENCY; i++) pipe_data[i] <= '0;
    end else begin
      pipe_valid[0] <= rd_acc;
      pipe_err[0]   <= rd_acc & ~in_range;
      pipe_data[0]  <= (rd_acc && in_range) ? mem[idx] : '0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_err[i]   <= pipe_err[i-1];
        pipe_data[i]  <= pipe_data[i-1];
      end
      if (wr_acc && !in_range) wr_err <= 1'b1;
    end
  end

  assign rsp_valid = pipe_valid[READ_LATENCY-1];
  assign rsp_err   = pipe_err[READ_LATENCY-1];
  assign rsp_rdata = pipe_data[READ_LATENCY-1];

endmodule
